// File: rtl/uart_line_echo_pkg.sv
// Shared definitions for the UART line-echo block.
// Holds the ASCII control codes the echo logic reacts to and emits, and the
// FSM state encoding used by the top level.
package uart_line_echo_pkg;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;
  localparam logic [7:0] AsciiBs = 8'h08;

  typedef enum logic [1:0] {
    StCollect,
    StSendData,
    StSendCr,
    StSendLf
  } state_e;

endpackage

// File: rtl/uart_line_echo_line_buf_ram.sv
// line_buf_ram: simple dual-port RAM (one write port, one synchronous read
// port), DEPTH x 8. It has no reset and a registered read, so it can map onto
// block RAM.
//   clk      - clock for both ports
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address, sampled on the rising edge
//   o_rdata  - data at i_raddr from the previous rising edge
module line_buf_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_line_echo.sv
// uart_line_echo: collects received bytes into a line buffer and, on the
// end-of-line byte, echoes the line followed by CR LF to the transmitter.
//   clk              - system clock, rising edge
//   resetn           - asynchronous active-low reset
//   i_rx_data        - received byte
//   i_rx_data_valid  - one-cycle strobe for i_rx_data, no backpressure
//   o_tx_data        - byte offered to the transmitter
//   o_tx_data_valid  - o_tx_data is valid (held until accepted)
//   i_tx_ready       - transmitter accepts the byte on this edge
//   o_line_overflow  - sticky, current line exceeded DEPTH bytes
//   o_rx_drop        - one-cycle pulse, a received byte was discarded
//   o_busy           - echo in progress, RX bytes are discarded
module uart_line_echo
  import uart_line_echo_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter logic [7:0]  EOL_CHAR = 8'h0D
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_data_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_data_valid,
  input  logic       i_tx_ready,
  output logic       o_line_overflow,
  output logic       o_rx_drop,
  output logic       o_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_count, w_count_d;
  logic [CW-1:0]   r_len, w_len_d;
  logic [CW-1:0]   r_rd_idx, w_rd_idx_d;
  logic [7:0]      r_tx_data, w_tx_data_d;
  logic            r_tx_valid, w_tx_valid_d;
  logic            r_overflow, w_overflow_d;
  logic            r_rx_drop, w_rx_drop_d;
  logic            w_we;
  logic [7:0]      w_rdata;
  logic            w_xfer;

  assign w_xfer = r_tx_valid & i_tx_ready;

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_len_d      = r_len;
    w_rd_idx_d   = r_rd_idx;
    w_tx_data_d  = r_tx_data;
    w_tx_valid_d = r_tx_valid;
    w_overflow_d = r_overflow;
    w_rx_drop_d  = 1'b0;
    w_we         = 1'b0;

    // Any byte arriving while echoing is lost.
    if (r_state != StCollect) begin
      w_rx_drop_d = i_rx_data_valid;
    end

    unique case (r_state)
      StCollect: begin
        if (i_rx_data_valid) begin
          if (i_rx_data == EOL_CHAR) begin
            w_len_d    = r_count;
            w_rd_idx_d = '0;
            w_state_d  = (r_count != '0) ? StSendData : StSendCr;
          end else if (i_rx_data == AsciiBs) begin
            if (r_count != '0) begin
              w_count_d = r_count - 1'b1;
            end
          end else if (r_count < CountFull) begin
            w_we      = 1'b1;
            w_count_d = r_count + 1'b1;
          end else begin
            w_overflow_d = 1'b1;
            w_rx_drop_d  = 1'b1;
          end
        end
      end

      // Each SEND state loads its byte when valid is low and clears valid on
      // transfer, giving exactly one idle cycle between bytes.
      StSendData: begin
        if (!r_tx_valid) begin
          w_tx_data_d  = w_rdata;
          w_tx_valid_d = 1'b1;
        end else if (i_tx_ready) begin
          w_tx_valid_d = 1'b0;
          if (r_rd_idx + 1'b1 < r_len) begin
            w_rd_idx_d = r_rd_idx + 1'b1;
          end else begin
            w_state_d = StSendCr;
          end
        end
      end

      StSendCr: begin
        if (!r_tx_valid) begin
          w_tx_data_d  = AsciiCr;
          w_tx_valid_d = 1'b1;
        end else if (i_tx_ready) begin
          w_tx_valid_d = 1'b0;
          w_state_d    = StSendLf;
        end
      end

      StSendLf: begin
        if (!r_tx_valid) begin
          w_tx_data_d  = AsciiLf;
          w_tx_valid_d = 1'b1;
        end else if (w_xfer) begin
          w_tx_valid_d = 1'b0;
          w_state_d    = StCollect;
          w_count_d    = '0;
          w_rd_idx_d   = '0;
          w_overflow_d = 1'b0;
        end
      end

      default: w_state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StCollect;
      r_count    <= '0;
      r_len      <= '0;
      r_rd_idx   <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_rx_drop  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_len      <= w_len_d;
      r_rd_idx   <= w_rd_idx_d;
      r_tx_data  <= w_tx_data_d;
      r_tx_valid <= w_tx_valid_d;
      r_overflow <= w_overflow_d;
      r_rx_drop  <= w_rx_drop_d;
    end
  end

  // Read address follows the next read index so the registered RAM output
  // already holds the right byte when the idle cycle loads it.
  line_buf_ram #(
    .DEPTH (DEPTH)
  ) u_line_buf_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (i_rx_data),
    .i_raddr (w_rd_idx_d[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign o_tx_data       = r_tx_data;
  assign o_tx_data_valid = r_tx_valid;
  assign o_line_overflow = r_overflow;
  assign o_rx_drop       = r_rx_drop;
  assign o_busy          = (r_state != StCollect);

endmodule
